yc_memmap_initiator: RTL and testbench

- NoC requester bridge: converts a simple local 16-bit load/store request port into OP_WRITE / OP_READ_REQ flits.
- Accepts the matching OP_READ_RESP flit and returns the read data on a local response port.
- Sits between a core/DMA-side master and a mesh router port. Talks to memory-map endpoints (DRAM 0x0000-0x7FFF, SPAD 0x8000-0x8FFF, MMIO 0xF000-0xF0FF).
- Single outstanding transaction.

---
 rtl/yc_memmap_initiator.sv | 236 +++++++++++++++++++++++
 tb/tb_yc_memmap_initiator.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/yc_memmap_initiator.sv
// NoC requester bridge: local 16-bit load/store port to request/response flits.
// Optional read-response timeout is enabled by defining YC_MMI_TIMEOUT_EN.
package yc_mmi_pkg;
    localparam int XW = 4;
    localparam int YW = 4;

    localparam logic [1:0] VC_REQ = 2'd0;
    localparam logic [1:0] VC_RSP = 2'd1;

    localparam logic [2:0] OP_WRITE     = 3'd1;
    localparam logic [2:0] OP_READ_REQ  = 3'd2;
    localparam logic [2:0] OP_READ_RESP = 3'd3;

    typedef struct packed {
        logic [1:0]    vc;
        logic [2:0]    opc;
        logic [3:0]    len;
        logic [XW-1:0] src_x;
        logic [YW-1:0] src_y;
        logic [XW-1:0] dst_x;
        logic [YW-1:0] dst_y;
        logic [31:0]   pay;
    } flit_t;

    function automatic flit_t build_flit(
        input logic [1:0]    vc,
        input logic [2:0]    opc,
        input logic [3:0]    len,
        input logic [XW-1:0] sx,
        input logic [YW-1:0] sy,
        input logic [XW-1:0] dx,
        input logic [YW-1:0] dy,
        input logic [31:0]   pay
    );
        flit_t f;
        f.vc    = vc;
        f.opc   = opc;
        f.len   = len;
        f.src_x = sx;
        f.src_y = sy;
        f.dst_x = dx;
        f.dst_y = dy;
        f.pay   = pay;
        return f;
    endfunction
endpackage

module yc_memmap_initiator
    import yc_mmi_pkg::*;
#(
    parameter int X_ID           = 0,
    parameter int Y_ID           = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [15:0]   req_addr,
    input  logic [15:0]   req_wdata,
    input  logic [XW-1:0] req_dst_x,
    input  logic [YW-1:0] req_dst_y,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [15:0]   resp_rdata,
    output logic          resp_err,
    output logic          tx_valid,
    output flit_t         tx_flit,
    input  logic          tx_ready,
    input  logic          rx_valid,
    input  flit_t         rx_flit,
    output logic          rx_ready,
    output logic          busy,
    output logic [7:0]    drop_cnt
);
    typedef enum logic [1:0] {IDLE, SEND, WAITR, RESP} st_t;

    localparam logic [XW-1:0] MY_X = XW'(X_ID);
    localparam logic [YW-1:0] MY_Y = YW'(Y_ID);

    st_t           st_q, st_d;
    logic          tx_valid_q, tx_valid_d;
    flit_t         tx_flit_q, tx_flit_d;
    logic          resp_valid_q, resp_valid_d;
    logic [15:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;
    logic [7:0]    drop_q, drop_d;
    logic [15:0]   addr_q, addr_d;
    logic [XW-1:0] dx_q, dx_d;
    logic [YW-1:0] dy_q, dy_d;
    logic          wr_q, wr_d;
    logic          rx_take, rx_hit, rx_drop;

`ifdef YC_MMI_TIMEOUT_EN
    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);
    logic [15:0] timer_q, timer_d;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    logic unused_rx;
    assign unused_rx = ^{rx_flit.vc, rx_flit.len};

    // A response must target us, come from the latched endpoint and echo our address.
    always_comb begin
        rx_take = rx_valid && rx_ready;
        rx_hit  = (st_q == WAITR) && rx_valid
               && (rx_flit.dst_x == MY_X) && (rx_flit.dst_y == MY_Y)
               && (rx_flit.opc == OP_READ_RESP)
               && (rx_flit.src_x == dx_q) && (rx_flit.src_y == dy_q)
               && (rx_flit.pay[31:16] == addr_q);
        rx_drop = rx_take && !rx_hit;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q         <= IDLE;
            tx_valid_q   <= 1'b0;
            tx_flit_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 16'h0;
            resp_err_q   <= 1'b0;
            drop_q       <= 8'h0;
            addr_q       <= 16'h0;
            dx_q         <= '0;
            dy_q         <= '0;
            wr_q         <= 1'b0;
`ifdef YC_MMI_TIMEOUT_EN
            timer_q      <= 16'h0;
`endif
        end else begin
            st_q         <= st_d;
            tx_valid_q   <= tx_valid_d;
            tx_flit_q    <= tx_flit_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            drop_q       <= drop_d;
            addr_q       <= addr_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            wr_q         <= wr_d;
`ifdef YC_MMI_TIMEOUT_EN
            timer_q      <= timer_d;
`endif
        end
    end

    // Next state plus the registered flit/response/drop values.
    always_comb begin
        st_d         = st_q;
        tx_valid_d   = tx_valid_q;
        tx_flit_d    = tx_flit_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        drop_d       = drop_q;
        addr_d       = addr_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        wr_d         = wr_q;
`ifdef YC_MMI_TIMEOUT_EN
        timer_d      = timer_q;
`endif
        unique case (st_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    dx_d       = req_dst_x;
                    dy_d       = req_dst_y;
                    wr_d       = req_write;
                    tx_flit_d  = build_flit(VC_REQ,
                                            req_write ? OP_WRITE : OP_READ_REQ,
                                            4'd1, MY_X, MY_Y,
                                            req_dst_x, req_dst_y,
                                            {req_addr, req_write ? req_wdata : 16'h0});
                    tx_valid_d = 1'b1;
                    st_d       = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    st_d       = wr_q ? IDLE : WAITR;
`ifdef YC_MMI_TIMEOUT_EN
                    timer_d    = 16'h0;
`endif
                end
            end
            WAITR: begin
                if (rx_hit) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = rx_flit.pay[15:0];
                    resp_err_d   = 1'b0;
                    st_d         = RESP;
                end
`ifdef YC_MMI_TIMEOUT_EN
                else if (timer_q == TMO) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 16'hDEAD;
                    resp_err_d   = 1'b1;
                    st_d         = RESP;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
`endif
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    st_d         = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
        if (rx_drop && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Port outputs.
    always_comb begin
        req_ready  = (st_q == IDLE);
        rx_ready   = (st_q != RESP);
        busy       = (st_q != IDLE);
        tx_valid   = tx_valid_q;
        tx_flit    = tx_flit_q;
        resp_valid = resp_valid_q;
        resp_rdata = resp_rdata_q;
        resp_err   = resp_err_q;
        drop_cnt   = drop_q;
    end
endmodule

// File: tb/tb_yc_memmap_initiator.sv
// Directed testbench for yc_memmap_initiator.
// Table-driven single-cycle vectors plus hand sequences for multi-cycle cases.
module tb_yc_memmap_initiator;
    import yc_mmi_pkg::*;

`ifdef YC_MMI_TIMEOUT_EN
    localparam int TMO = 10;
`else
    localparam int TMO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [15:0]   req_addr, req_wdata;
    logic [XW-1:0] req_dst_x;
    logic [YW-1:0] req_dst_y;
    logic          resp_valid, resp_ready, resp_err;
    logic [15:0]   resp_rdata;
    logic          tx_valid, tx_ready, rx_valid, rx_ready, busy;
    flit_t         tx_flit, rx_flit;
    logic [7:0]    drop_cnt;

    int checks = 0;
    int errors = 0;
    int exp_drop = 0;

    always #5 clk = ~clk;

    yc_memmap_initiator #(
        .X_ID(0), .Y_ID(0), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_dst_x(req_dst_x), .req_dst_y(req_dst_y),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .tx_valid(tx_valid), .tx_flit(tx_flit), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_flit(rx_flit), .rx_ready(rx_ready),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic          rv;
        logic          wr;
        logic [15:0]   addr;
        logic [15:0]   wd;
        logic [XW-1:0] dx;
        logic [YW-1:0] dy;
        logic          txr;
        logic          rxv;
        flit_t         rxf;
        logic          rsr;
        logic          e_rdy;
        logic          e_txv;
        logic          e_busy;
        logic          e_rv;
        logic [15:0]   e_rd;
        logic [7:0]    e_drop;
        logic          e_rxr;
        flit_t         e_flit;
    } vec_t;

    vec_t v[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic flit_t rsp(input logic [XW-1:0] sx, input logic [YW-1:0] sy,
                                  input logic [31:0] pay);
        return build_flit(VC_RSP, OP_READ_RESP, 4'd1, sx, sy, 4'd0, 4'd0, pay);
    endfunction

    function automatic flit_t rdreq(input logic [XW-1:0] dx, input logic [YW-1:0] dy,
                                    input logic [15:0] a);
        return build_flit(VC_REQ, OP_READ_REQ, 4'd1, 4'd0, 4'd0, dx, dy, {a, 16'h0});
    endfunction

    task automatic idle_inputs();
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 16'h0;
        req_wdata  = 16'h0;
        req_dst_x  = '0;
        req_dst_y  = '0;
        tx_ready   = 1'b0;
        rx_valid   = 1'b0;
        rx_flit    = '0;
        resp_ready = 1'b0;
    endtask

    // Full read with an endpoint replying `lat` cycles after the request leaves.
    task automatic read_txn(input logic [15:0] a, input logic [XW-1:0] dx,
                            input logic [YW-1:0] dy, input logic [15:0] d,
                            input int lat, input int hold);
        bit got;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a;
        req_wdata = 16'hFFFF; req_dst_x = dx; req_dst_y = dy;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        chk("rd.tx_valid", 64'(tx_valid), 64'h1);
        chk("rd.tx_flit", 64'(tx_flit), 64'(rdreq(dx, dy, a)));
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rd.tx_done", 64'({tx_valid, busy, req_ready}), 64'b010);
        tx_ready = 1'b0;
        repeat (lat) @(negedge clk);
        rx_valid = 1'b1;
        rx_flit  = rsp(dx, dy, {a, d});
        @(negedge clk);
        rx_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (resp_valid) got = 1;
            else @(negedge clk);
        end
        chk("rd.resp_seen", 64'(got), 64'h1);
        chk("rd.rdata", 64'(resp_rdata), 64'(d));
        chk("rd.err", 64'(resp_err), 64'h0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rd.hold", 64'({resp_valid, rx_ready, resp_rdata}), 64'({1'b1, 1'b0, d}));
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rd.release", 64'({resp_valid, busy, req_ready}), 64'b001);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        flit_t wf, rf, junk;
        bit got;
        int n;
        wf = build_flit(VC_REQ, OP_WRITE, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 32'h00101234);
        rf = rdreq(4'd3, 4'd3, 16'hF000);
        junk = build_flit(VC_REQ, OP_WRITE, 4'd1, 4'd5, 4'd5, 4'd9, 4'd9, 32'h12345678);

        //        rv wr addr      wd       dx dy txr rxv rxf                     rsr rdy txv bsy rv rd       drop rxr flit
        v[0]  = '{1, 1, 16'h0010, 16'h1234, 1, 0, 0, 0, '0,                      0,  0,  1,  1,  0, 16'h0,    0, 1, wf};
        v[1]  = '{0, 0, 16'h0,    16'h0,    0, 0, 0, 0, '0,                      0,  0,  1,  1,  0, 16'h0,    0, 1, wf};
        v[2]  = '{0, 0, 16'h0,    16'h0,    0, 0, 0, 0, '0,                      0,  0,  1,  1,  0, 16'h0,    0, 1, wf};
        v[3]  = '{0, 0, 16'h0,    16'h0,    0, 0, 0, 0, '0,                      0,  0,  1,  1,  0, 16'h0,    0, 1, wf};
        v[4]  = '{0, 0, 16'h0,    16'h0,    0, 0, 1, 0, '0,                      0,  1,  0,  0,  0, 16'h0,    0, 1, wf};
        v[5]  = '{1, 0, 16'hF000, 16'h5555, 3, 3, 0, 0, '0,                      0,  0,  1,  1,  0, 16'h0,    0, 1, rf};
        v[6]  = '{0, 0, 16'h0,    16'h0,    0, 0, 1, 0, '0,                      0,  0,  0,  1,  0, 16'h0,    0, 1, rf};
        v[7]  = '{0, 0, 16'h0,    16'h0,    0, 0, 0, 1, rsp(3, 3, 32'hF0021111), 0,  0,  0,  1,  0, 16'h0,    1, 1, rf};
        v[8]  = '{0, 0, 16'h0,    16'h0,    0, 0, 0, 1, rsp(2, 0, 32'hF000434B), 0,  0,  0,  1,  0, 16'h0,    2, 1, rf};
        v[9]  = '{0, 0, 16'h0,    16'h0,    0, 0, 0, 1, rsp(3, 3, 32'hF000434B), 0,  0,  0,  1,  1, 16'h434B, 2, 0, rf};
        v[10] = '{0, 0, 16'h0,    16'h0,    0, 0, 0, 1, junk,                    0,  0,  0,  1,  1, 16'h434B, 2, 0, rf};
        v[11] = '{0, 0, 16'h0,    16'h0,    0, 0, 0, 0, '0,                      1,  1,  0,  0,  0, 16'h434B, 2, 1, rf};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.outs", 64'({req_ready, tx_valid, resp_valid, resp_err, busy, rx_ready}),
            64'b100001);
        chk("rst.flit", 64'(tx_flit), 64'h0);
        chk("rst.rdata", 64'(resp_rdata), 64'h0);
        chk("rst.drop", 64'(drop_cnt), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            req_valid = v[i].rv; req_write = v[i].wr; req_addr = v[i].addr;
            req_wdata = v[i].wd; req_dst_x = v[i].dx; req_dst_y = v[i].dy;
            tx_ready = v[i].txr; rx_valid = v[i].rxv; rx_flit = v[i].rxf;
            resp_ready = v[i].rsr;
            @(posedge clk); #1;
            chk($sformatf("v%0d.req_ready", i), 64'(req_ready), 64'(v[i].e_rdy));
            chk($sformatf("v%0d.tx_valid", i), 64'(tx_valid), 64'(v[i].e_txv));
            chk($sformatf("v%0d.busy", i), 64'(busy), 64'(v[i].e_busy));
            chk($sformatf("v%0d.resp_valid", i), 64'(resp_valid), 64'(v[i].e_rv));
            chk($sformatf("v%0d.drop_cnt", i), 64'(drop_cnt), 64'(v[i].e_drop));
            chk($sformatf("v%0d.rx_ready", i), 64'(rx_ready), 64'(v[i].e_rxr));
            if (v[i].e_txv)
                chk($sformatf("v%0d.tx_flit", i), 64'(tx_flit), 64'(v[i].e_flit));
            if (v[i].e_rv)
                chk($sformatf("v%0d.rdata", i), 64'({resp_err, resp_rdata}),
                    64'({1'b0, v[i].e_rd}));
        end
        exp_drop = 2;
        @(negedge clk);
        idle_inputs();

        read_txn(16'hF000, 4'd3, 4'd3, 16'h434B, 3, 5);
        chk("rdA.drop", 64'(drop_cnt), 64'(exp_drop));

`ifdef YC_MMI_TIMEOUT_EN
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0040;
        req_dst_x = 4'd1; req_dst_y = 4'd1; tx_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        got = 0;
        n = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (resp_valid) got = 1;
        end
        chk("tmo.seen", 64'(got), 64'h1);
        chk("tmo.latency", 64'(n), 64'(TMO + 1));
        chk("tmo.data", 64'({resp_err, resp_rdata}), 64'({1'b1, 16'hDEAD}));
        @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        rx_valid = 1'b1;
        rx_flit = rsp(4'd1, 4'd1, 32'h00407777);
        @(negedge clk);
        rx_valid = 1'b0;
        exp_drop++;
        chk("tmo.late_drop", 64'(drop_cnt), 64'(exp_drop));
        chk("tmo.idle", 64'({busy, resp_valid}), 64'b00);
`endif

        @(negedge clk);
        rx_valid = 1'b1;
        rx_flit = junk;
        repeat (260) @(negedge clk);
        rx_valid = 1'b0;
        chk("drop.sat", 64'(drop_cnt), 64'hFF);

        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0100;
        req_dst_x = 4'd2; req_dst_y = 4'd2; tx_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        tx_ready = 1'b0;
        chk("rstw.in_waitr", 64'({busy, tx_valid, rx_ready}), 64'b101);
        #2;
        rst = 1'b1;
        #1;
        chk("rstw.outs", 64'({req_ready, tx_valid, resp_valid, resp_err, busy, rx_ready}),
            64'b100001);
        chk("rstw.flit", 64'(tx_flit), 64'h0);
        chk("rstw.rdata", 64'(resp_rdata), 64'h0);
        chk("rstw.drop", 64'(drop_cnt), 64'h0);
        @(posedge clk);
        rst = 1'b0;
        read_txn(16'h8000, 4'd2, 4'd1, 16'hABCD, 2, 0);
        chk("rstw.drop_after", 64'(drop_cnt), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1);
    end
endmodule
